dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 6 +
 rtl/dmem_array.sv | 20 ++
 rtl/dmem_responder.sv | 86 ++++++++
 tb/tb_dmem_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared word width, wait-counter width and FSM encoding for the data-memory responder
package dmem_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^ADDR_W x DATA_W word store with synchronous write/clear and combinational read
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = dmem_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge Clk)
        if (!Rst)
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        else if (we)
            mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with WAIT_CYCLES wait states; DMEM_ERR_EN enables out-of-range errors
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = dmem_pkg::DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);
    import dmem_pkg::*;
    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              wr_q, err_q, addr_err, accept, go_resp;
    logic              cur_write, cur_err;
    logic [ADDR_W-1:0] addr_q, cur_addr;
    logic [DATA_W-1:0] wdata_q, cur_wdata, mem_rdata;
`ifdef DMEM_ERR_EN
    assign addr_err = |req_addr[15:ADDR_W];
`else
    logic unused_addr;
    assign unused_addr = ^req_addr[15:ADDR_W];
    assign addr_err    = 1'b0;
`endif
    // With zero wait states the response edge is the accept edge, so use the live request in IDLE
    assign cur_write = (state == IDLE) ? req_write : wr_q;
    assign cur_err   = (state == IDLE) ? addr_err : err_q;
    assign cur_addr  = (state == IDLE) ? req_addr[ADDR_W-1:0] : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = (state == IDLE) && req_valid;
        if (accept) begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else if (state == WAIT) begin
            cnt_d   = cnt - 1'b1;
            state_d = (cnt == CNT_W'(1)) ? RESP : WAIT;
        end else if (state == RESP) begin
            state_d = IDLE;
        end
        go_resp   = (state_d == RESP) && (state != RESP);
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = (state == RESP) && err_q;
        stall     = (state != IDLE) || req_valid;
    end
    always_ff @(posedge Clk)
        if (!Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                err_q   <= addr_err;
                addr_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
            end
            if (go_resp)
                rsp_rdata <= (cur_write || cur_err) ? '0 : mem_rdata;
        end
    dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .Clk  (Clk),
        .Rst  (Rst),
        .we   (go_resp && cur_write && !cur_err),
        .addr (cur_addr),
        .wdata(cur_wdata),
        .rdata(mem_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with 2 and 0 wait states
module tb_dmem_responder;
    localparam int WC = 2;
    logic        Clk = 1'b0, Rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0, rsp_rdata;
    logic        req_ready, rsp_valid, rsp_err, stall;
    logic        b_valid = 1'b0, b_write = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic        b_ready, b_rsp_valid, b_err, b_stall;
    int          checks = 0, errors = 0;
    always #5 Clk = ~Clk;
    dmem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(WC)) u_dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
    );
    dmem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .req_valid(b_valid), .req_write(b_write),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_ready),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err), .stall(b_stall)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    // One request on the WC-wait-state responder, checking handshake, latency and response
    task automatic a_req(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic hold, input logic [15:0] exp_d, input logic exp_e);
        int k;
        @(negedge Clk);
        check({tag, "_idle_stall"}, stall, 0);
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        #1;
        check({tag, "_req_stall"}, stall, 1);
        k = 0;
        do begin
            @(negedge Clk);
            k++;
            req_valid = hold;
            #1;
            check({tag, "_busy_ready"}, req_ready, 0);
            check({tag, "_busy_stall"}, stall, 1);
        end while (!rsp_valid && k < 20);
        req_valid = 1'b0;
        check({tag, "_latency"}, k, WC + 1);
        check({tag, "_rdata"}, rsp_rdata, exp_d);
        check({tag, "_err"}, rsp_err, exp_e);
        @(negedge Clk);
        check({tag, "_pulse"}, rsp_valid, 0);
        check({tag, "_rdata_hold"}, rsp_rdata, exp_d);
    endtask
    initial begin
        int n;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 16'h0000);
        check("rst_err", rsp_err, 0);
        a_req("ld_10", 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0);
        a_req("st_a5", 1'b1, 16'h00A5, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
        a_req("ld_a5", 1'b0, 16'h00A5, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
        a_req("st_ff", 1'b1, 16'h00FF, 16'h7E57, 1'b1, 16'h0000, 1'b0);
        a_req("ld_ff", 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h7E57, 1'b0);
`ifdef DMEM_ERR_EN
        a_req("st_105", 1'b1, 16'h0105, 16'hAAAA, 1'b0, 16'h0000, 1'b1);
        a_req("ld_005", 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0);
`else
        a_req("st_105", 1'b1, 16'h0105, 16'hAAAA, 1'b0, 16'h0000, 1'b0);
        a_req("ld_005", 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hAAAA, 1'b0);
`endif
        @(negedge Clk);
        b_valid = 1'b1; b_write = 1'b1; b_addr = 16'h0003; b_wdata = 16'h1234;
        @(negedge Clk);
        b_valid = 1'b0;
        check("z_st_valid", b_rsp_valid, 1);
        check("z_st_rdata", b_rdata, 16'h0000);
        @(negedge Clk);
        check("z_idle_ready", b_ready, 1);
        b_valid = 1'b1; b_write = 1'b0;
        @(negedge Clk);
        b_valid = 1'b0;
        check("z_ld_valid", b_rsp_valid, 1);
        check("z_ld_rdata", b_rdata, 16'h1234);
        check("z_ld_ready", b_ready, 0);
        @(negedge Clk);
        check("z_next_ready", b_ready, 1);
        check("z_next_valid", b_rsp_valid, 0);
        @(negedge Clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0007; req_wdata = 16'h5555;
        @(negedge Clk);
        req_valid = 1'b0;
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("mrst_ready", req_ready, 1);
        check("mrst_stall", stall, 0);
        n = 0;
        repeat (5) begin
            @(negedge Clk);
            n += int'(rsp_valid);
        end
        check("mrst_no_rsp", n, 0);
        a_req("ld_07", 1'b0, 16'h0007, 16'h0000, 1'b0, 16'h0000, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
